// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// The in-order pipeline writeback (A) has priority. Long-latency results (B)
// are buffered in a small FIFO and drained whenever A leaves the port free.
// A pending-destination scoreboard tracks B results not yet committed, and a
// starvation counter asks the pipeline for a bubble when B waits too long.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_valid,
    input  logic [ADDR_W-1:0]             a_addr,
    input  logic [DATA_W-1:0]             a_data,
    output logic                          a_stall_req,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [ADDR_W-1:0]             b_addr,
    input  logic [DATA_W-1:0]             b_data,
    input  logic                          iss_valid,
    input  logic [ADDR_W-1:0]             iss_rd,
    input  logic [ADDR_W-1:0]             rs1,
    input  logic [ADDR_W-1:0]             rs2,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic                          rf_we,
    output logic [ADDR_W-1:0]             rf_waddr,
    output logic [DATA_W-1:0]             rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;
    localparam int SC_W  = $clog2(STARVE_LIM + 1);

    logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;

    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_next;
    logic [SC_W-1:0]   starve_cnt;
    logic [SC_W-1:0]   starve_next;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              a_win;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign full      = (cnt == CNT_W'(FIFO_DEPTH));
    assign empty     = (cnt == '0);
    assign b_ready   = !full;
    assign push      = b_valid && !full;
    assign a_win     = a_valid && (a_addr != '0);
    // Only entries already stored are poppable, so a fresh push never bypasses.
    assign pop       = !a_win && !empty;
    assign head_addr = q_addr[rd_ptr];
    assign head_data = q_data[rd_ptr];
    assign fifo_cnt  = cnt;

    assign rs1_busy  = (rs1 != '0) && pending[rs1];
    assign rs2_busy  = (rs2 != '0) && pending[rs2];

    // FIFO storage: contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= b_addr;
            q_data[wr_ptr] <= b_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Scoreboard update: clear on B commit, then set on issue so set wins.
    always_comb begin
        pending_next = pending;
        if (pop) pending_next[head_addr] = 1'b0;
        if (iss_valid && (iss_rd != '0)) pending_next[iss_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_next;
    end

    // Starvation counter: counts waiting cycles of a buffered B write, saturating.
    always_comb begin
        starve_next = '0;
        if (!pop && !empty) begin
            if (starve_cnt >= SC_W'(STARVE_LIM)) starve_next = SC_W'(STARVE_LIM);
            else                                 starve_next = starve_cnt + 1'b1;
        end
    end

    // Starvation state and registered bubble request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt  <= '0;
            a_stall_req <= 1'b0;
        end else begin
            starve_cnt  <= starve_next;
            a_stall_req <= (starve_next >= SC_W'(STARVE_LIM));
        end
    end

    // Registered write port; address/data hold when no write is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (a_win) begin
            rf_we    <= 1'b1;
            rf_waddr <= a_addr;
            rf_wdata <= a_data;
        end else if (pop) begin
            rf_we    <= (head_addr != '0);
            rf_waddr <= head_addr;
            rf_wdata <= head_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_regfile_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int LIM   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_data = '0;
    logic          a_stall_req;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_data = '0;
    logic          iss_valid = 1'b0;
    logic [AW-1:0] iss_rd = '0;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [$clog2(DEPTH):0] fifo_cnt;

    regfile_wb_arbiter #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .FIFO_DEPTH(DEPTH),
        .STARVE_LIM(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .a_stall_req(a_stall_req),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered B writes, a pending bit per register,
    // a waiting-cycle count, and the write expected on the port.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } bent_t;

    bent_t         bq[$];
    bit            pend[1<<AW];
    int            starve;
    bit            exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    bit            exp_stall;
    bit            last_push;

    task automatic model_clear();
        bq.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        starve    = 0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_stall = 1'b0;
        last_push = 1'b0;
    endtask

    task automatic check_comb();
        check("b_ready",  b_ready,  bq.size() < DEPTH);
        check("fifo_cnt", fifo_cnt, bq.size());
        check("rs1_busy", rs1_busy, (rs1 != 0) && pend[rs1]);
        check("rs2_busy", rs2_busy, (rs2 != 0) && pend[rs2]);
    endtask

    // One clock: inputs are already driven; check, clock, update model, check.
    task automatic cycle();
        bit    a_win, pop, push;
        int    sz;
        bent_t h, nb;
        #3;
        check_comb();
        if (iss_valid && iss_rd != 0) check("iss_to_pending_rd", pend[iss_rd], 1'b0);
        sz    = bq.size();
        a_win = a_valid && (a_addr != 0);
        pop   = !a_win && (sz > 0);
        push  = b_valid && (sz < DEPTH);
        nb.a  = b_addr;
        nb.d  = b_data;
        if (a_win) begin
            exp_we = 1'b1; exp_addr = a_addr; exp_data = a_data;
        end else if (pop) begin
            h = bq[0];
            exp_we = (h.a != 0); exp_addr = h.a; exp_data = h.d;
        end else begin
            exp_we = 1'b0;
        end
        @(posedge clk);
        #1;
        if (pop) begin
            h = bq.pop_front();
            pend[h.a] = 1'b0;
        end
        if (push) bq.push_back(nb);
        if (iss_valid && iss_rd != 0) pend[iss_rd] = 1'b1;
        if (pop)          starve = 0;
        else if (sz > 0)  starve = (starve + 1 > LIM) ? LIM : starve + 1;
        else              starve = 0;
        exp_stall = (starve >= LIM);
        last_push = push;
        check("rf_we", rf_we, exp_we);
        if (exp_we) begin
            check("rf_waddr", rf_waddr, exp_addr);
            check("rf_wdata", rf_wdata, exp_data);
        end
        check("a_stall_req", a_stall_req, exp_stall);
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    task automatic do_reset_checks();
        model_clear();
        check("rst_fifo_cnt", fifo_cnt, 0);
        check("rst_b_ready",  b_ready, 1);
        check("rst_rf_we",    rf_we, 0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_stall",    a_stall_req, 0);
        check("rst_rs1_busy", rs1_busy, 0);
        check("rst_rs2_busy", rs2_busy, 0);
    endtask

    initial begin
        // Power-on reset and idle state.
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset_checks();
        for (int i = 0; i < (1 << AW); i++) begin
            rs1 = AW'(i);
            #0.1;
            check("idle_rs1_busy", rs1_busy, 0);
        end
        rst = 1'b0;
        rs1 = '0;

        // First A write.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hAA;
        cycle();
        check("first_a_addr", rf_waddr, 5);
        check("first_a_data", rf_wdata, 32'hAA);
        idle_inputs();
        cycle();

        // Scoreboard round trip on register 9.
        iss_valid = 1'b1; iss_rd = 5'd9; rs1 = 5'd9;
        cycle();
        iss_valid = 1'b0;
        check("sb_busy9", rs1_busy, 1);
        cycle(); cycle();
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h1234;
        cycle();
        b_valid = 1'b0;
        check("sb_busy_before_pop", rs1_busy, 1);
        cycle();
        check("sb_b_we", rf_we, 1);
        check("sb_b_addr", rf_waddr, 9);
        check("sb_b_data", rf_wdata, 32'h1234);
        cycle();
        check("sb_busy_cleared", rs1_busy, 0);

        // Priority, buffering and starvation.
        for (int i = 1; i < 40 && !exp_stall; i++) begin
            a_valid = 1'b1; a_addr = AW'((i - 1) % 31 + 1); a_data = 32'h100 + i;
            b_valid = (i == 2 || i == 3);
            b_addr  = (i == 2) ? 5'd10 : 5'd11;
            b_data  = 32'hB000 + i;
            cycle();
            if (i == 3) check("buf_full_ready", b_ready, 0);
        end
        check("starve_stall", a_stall_req, 1);
        idle_inputs();
        cycle();
        check("starve_pop_addr", rf_waddr, 10);
        check("starve_cleared", a_stall_req, 0);
        cycle();

        // Address-0 corners.
        b_valid = 1'b1; b_addr = '0; b_data = 32'hDEAD;
        cycle();
        idle_inputs();
        cycle();
        check("b_addr0_no_we", rf_we, 0);
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h33;
        cycle();
        b_valid = 1'b0; a_valid = 1'b1; a_addr = '0; a_data = 32'hFFFF;
        cycle();
        check("a_addr0_b_pops", rf_waddr, 3);
        idle_inputs();
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77;
        cycle();
        b_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd7; rs2 = 5'd7;
        cycle();
        idle_inputs();
        check("set_wins_7", rs2_busy, 1);
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h78;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        check("pend7_cleared", rs2_busy, 0);

        // Reset in the middle of traffic.
        iss_valid = 1'b1; iss_rd = 5'd12;
        a_valid = 1'b1; a_addr = 5'd1; b_valid = 1'b1; b_addr = 5'd12; b_data = 32'hC12;
        cycle();
        iss_rd = 5'd13; b_addr = 5'd13; b_data = 32'hC13;
        cycle();
        iss_valid = 1'b0; b_valid = 1'b0;
        rs1 = 5'd12; rs2 = 5'd13;
        #3;
        check("pre_rst_cnt", fifo_cnt, 2);
        rst = 1'b1;
        #1;
        idle_inputs();
        do_reset_checks();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic following the pipeline and handshake rules.
        for (int n = 0; n < 600; n++) begin
            a_valid = !exp_stall && ($urandom_range(0, 99) < 55);
            a_addr  = AW'($urandom_range(0, 31));
            a_data  = $urandom;
            if (!b_valid || last_push) begin
                b_valid = ($urandom_range(0, 99) < 45);
                b_addr  = AW'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            iss_rd    = AW'($urandom_range(1, 31));
            iss_valid = ($urandom_range(0, 99) < 30) && !pend[iss_rd];
            rs1 = AW'($urandom_range(0, 31));
            rs2 = AW'($urandom_range(0, 31));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Schedules the single register-file write port (write enable, write address, write data) between two requesters.
- Requester A is the in-order pipeline writeback; it has priority and no ready signal.
- Requester B is a long-latency unit (load/mul/div) with a valid/ready handshake, buffered in a small FIFO.
- Keeps a pending-destination scoreboard so hazard logic can stall readers of registers whose B result has not yet committed.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (2**ADDR_W registers; address 0 hardwired zero)
FIFO_DEPTH, 2, B-side buffer entries (power of two, >=2)
STARVE_LIM, 4, cycles a buffered B write may wait before requesting an A bubble

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  pipeline writeback valid; always accepted
- a_addr  in  ADDR_W  pipeline destination register
- a_data  in  DATA_W  pipeline writeback data
- a_stall_req  out  1  request that the pipeline insert one writeback bubble
- b_valid  in  1  long-latency result valid
- b_ready  out  1  FIFO can accept a B result
- b_addr  in  ADDR_W  B destination register
- b_data  in  DATA_W  B result data
- iss_valid  in  1  long-latency op issued this cycle
- iss_rd  in  ADDR_W  destination of the issued op
- rs1  in  ADDR_W  hazard query address 1
- rs2  in  ADDR_W  hazard query address 2
- rs1_busy  out  1  rs1 has an uncommitted B write (combinational)
- rs2_busy  out  1  rs2 has an uncommitted B write (combinational)
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- fifo_cnt  out  clog2(FIFO_DEPTH)+1  buffered B entries

Behaviour:
- Reset (asynchronous, any cycle):
  - FIFO empty, pending vector 0, starve counter 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, a_stall_req=0, b_ready=1, fifo_cnt=0.
  - Buffered writes are discarded.
- B accept: b_ready = !full. A push occurs when b_valid && b_ready. A push into a full FIFO is impossible; b_valid while full holds until ready.
- Grant, evaluated every cycle:
  - If a_valid and a_addr!=0, A wins.
  - Otherwise, if the FIFO is non-empty, pop the head.
  - Otherwise idle.
- Output latency: the granted write appears on rf_* exactly 1 cycle after grant. rf_we=1 only for a write with a nonzero address.
- Address-0 writes:
  - A writes to address 0 are ignored and do not consume the port.
  - B writes to address 0 are popped when granted, with rf_we=0.
- Simultaneous push and pop: fifo_cnt unchanged. A push into an empty FIFO is not poppable in the same cycle (no bypass); minimum B latency is 2 cycles from b_valid to rf_we.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets pending[iss_rd].
  - A B pop clears pending[head address].
  - Set and clear of the same address in the same cycle: set wins.
  - rsN_busy = pending[rsN]; rsN=0 always reads 0.
  - iss_valid to an already-pending rd is illegal; hazard logic prevents it, and the bench asserts it never occurs.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and no pop occurs; it clears on a pop.
  - a_stall_req is registered and asserted when counter >= STARVE_LIM; it holds until the next pop.
  - The pipeline must deassert a_valid (or present address 0) the cycle after a_stall_req, which guarantees a pop.
- Counter saturates at STARVE_LIM.

Test Plan:
- Reset then idle: rf_we=0, b_ready=1, rs1_busy=0 for all addresses; release reset, then a_valid, a_addr=5, a_data=0xAA → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xAA.
- Scoreboard round-trip: iss_valid with iss_rd=9 → rs1=9 gives busy=1; 3 cycles later b_valid with b_addr=9, b_data=0x1234 and A idle → rf_we with addr 9 and data 0x1234 two cycles after b_valid; busy=0 the cycle after the pop.
- Priority and buffering: a_valid continuous to addresses 1..6 while B pushes addresses 10 and 11 → both buffered, b_ready=0 at fifo_cnt=2, A writes appear in order, no B write yet.
- Starvation: keep A busy → a_stall_req=1 after 4 waiting cycles; drop a_valid for one cycle → B addr 10 written, counter cleared, a_stall_req=0 next cycle.
- Corner cases: B write to address 0 pops with rf_we=0; A write to address 0 lets the FIFO head pop the same cycle; iss_rd=7 set and clear in the same cycle leaves pending[7]=1.
- Reset mid-operation: FIFO holding 2 entries and pending bits set, assert rst → next edge shows fifo_cnt=0, all busy=0, rf_we=0, and no stale writes appear after release.
